spi_master: RTL



---
 rtl/spi_cnn_pkg.sv | 21 ++
 rtl/spi_clk_gen.sv | 55 +++++
 rtl/spi_master.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/spi_cnn_pkg.sv
// Shared types and constants for the CNN-side SPI master.
package spi_cnn_pkg;

  localparam int SPI_WORD_W      = 32;
  localparam int SPI_MIN_CLK_DIV = 3;
  localparam int SPI_MIN_CS_GAP  = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_XFER  = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } spi_mst_state_t;

  // States in which cs_n is asserted and the SPI clock generator runs.
  function automatic logic in_frame(input spi_mst_state_t s);
    return (s == ST_SETUP) || (s == ST_XFER);
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SPI clock generator: half-period counter toggling sclk, with rise/fall
// strobes asserted in the clk cycle before sclk changes level.
module spi_clk_gen
  import spi_cnn_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int            CW   = $clog2(CLK_DIV);
  localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic          term;

  assign term = en && (cnt_q == TERM);
  assign rise = term && !sclk_q;
  assign fall = term && sclk_q;
  assign sclk = sclk_q;

  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (clr) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (en) begin
      if (term) begin
        cnt_d  = '0;
        sclk_d = !sclk_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Mode-0 MSB-first 32-bit SPI master, one cs_n frame per accepted word.
// Optional response checker (rx == previous tx + 1) under SPI_MASTER_CHECK_EN.
module spi_master
  import spi_cnn_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SPI_WORD_W-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [SPI_WORD_W-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  resp_err,
  output logic                  busy,
  output logic                  sclk,
  output logic                  cs_n,
  output logic                  mosi,
  input  logic                  miso
);

  if (CLK_DIV < SPI_MIN_CLK_DIV) begin : g_bad_clk_div
    $error("spi_master: CLK_DIV must be at least 3");
  end
  if (CS_GAP < SPI_MIN_CS_GAP) begin : g_bad_cs_gap
    $error("spi_master: CS_GAP must be at least 2");
  end

  localparam int            GW       = $clog2(CS_GAP);
  localparam logic [GW-1:0] GAP_TERM = GW'(CS_GAP - 1);
  localparam logic [4:0]    BIT_LAST = 5'(SPI_WORD_W - 1);

  spi_mst_state_t        state_q, state_d;
  logic [SPI_WORD_W-1:0] tx_sr_q, tx_sr_d;
  logic [SPI_WORD_W-1:0] rx_sr_q, rx_sr_d;
  logic [SPI_WORD_W-1:0] rx_data_q, rx_data_d;
  logic [4:0]            bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  cs_n_q, cs_n_d;
  logic                  mosi_q, mosi_d;
  logic                  busy_q, busy_d;
  logic                  tx_ready_q, tx_ready_d;
  logic                  rise, fall, accept, end_xfer;

  assign accept   = tx_valid && tx_ready_q;
  // The rise strobe after the last bit's low phase ends the frame instead of
  // starting a 33rd bit; it also clears the clock generator back to idle.
  assign end_xfer = (state_q == ST_XFER) && rise && (bit_cnt_q == BIT_LAST);

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (in_frame(state_q)),
    .clr  (end_xfer),
    .sclk (sclk),
    .rise (rise),
    .fall (fall)
  );

  always_comb begin
    state_d    = state_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    mosi_d     = mosi_q;
    rx_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_SETUP;
          tx_sr_d   = tx_data;
          bit_cnt_d = '0;
          mosi_d    = tx_data[SPI_WORD_W-1];
        end
      end
      ST_SETUP: begin
        if (rise) begin
          state_d = ST_XFER;
          rx_sr_d = {rx_sr_q[SPI_WORD_W-2:0], miso};
        end
      end
      ST_XFER: begin
        if (end_xfer) begin
          state_d   = ST_GAP;
          gap_cnt_d = '0;
          mosi_d    = 1'b0;
        end else if (rise) begin
          rx_sr_d   = {rx_sr_q[SPI_WORD_W-2:0], miso};
          bit_cnt_d = bit_cnt_q + 5'd1;
        end else if (fall) begin
          tx_sr_d = tx_sr_q << 1;
          mosi_d  = (bit_cnt_q == BIT_LAST) ? 1'b0 : tx_sr_q[SPI_WORD_W-2];
        end
      end
      ST_GAP: begin
        mosi_d = 1'b0;
        if (gap_cnt_q == GAP_TERM) begin
          state_d = ST_DONE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d    = ST_IDLE;
        rx_data_d  = rx_sr_q;
        rx_valid_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    cs_n_d     = !in_frame(state_d);
    busy_d     = (state_d != ST_IDLE);
    tx_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      rx_valid_q <= 1'b0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      tx_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      rx_valid_q <= rx_valid_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      tx_ready_q <= tx_ready_d;
    end
  end

  assign tx_ready = tx_ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;
  assign cs_n     = cs_n_q;
  assign mosi     = mosi_q;

`ifdef SPI_MASTER_CHECK_EN
  // The slave echoes word N as N+1 during frame N+1, so each response is
  // compared against the word sent in the previous frame.
  logic [SPI_WORD_W-1:0] cur_tx_q, cur_tx_d, prev_tx_q, prev_tx_d;
  logic                  prev_valid_q, prev_valid_d, resp_err_q, resp_err_d;

  always_comb begin
    cur_tx_d     = cur_tx_q;
    prev_tx_d    = prev_tx_q;
    prev_valid_d = prev_valid_q;
    resp_err_d   = 1'b0;
    if (accept) begin
      cur_tx_d = tx_data;
    end
    if (state_q == ST_DONE) begin
      resp_err_d   = prev_valid_q && (rx_sr_q != prev_tx_q + 32'd1);
      prev_tx_d    = cur_tx_q;
      prev_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_tx_q     <= '0;
      prev_tx_q    <= '0;
      prev_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      cur_tx_q     <= cur_tx_d;
      prev_tx_q    <= prev_tx_d;
      prev_valid_q <= prev_valid_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign resp_err = resp_err_q;
`else
  assign resp_err = 1'b0;
`endif

endmodule
